// File: rtl/time_keeper.sv
// HH:MM:SS clock with two-button set mode, blinking digit blanking and set-mode timeout.
// Define TIME_12H_EN for a 12-hour display with PM indicator (default build is 24-hour).
module time_keeper #(
  parameter int unsigned SET_TIMEOUT_S = 30
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_out_1Hz,
  input  logic       clk_out_5Hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [3:0] blank,
  output logic       colon,
  output logic       pm
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] SET_HH = 2'd1;
  localparam logic [1:0] SET_MM = 2'd2;

`ifdef TIME_12H_EN
  localparam logic [7:0] HH_RST = 8'h12;
`else
  localparam logic [7:0] HH_RST = 8'h00;
`endif

  logic        t1_r, t1_p, t5_r, t5_p;
  logic        mode_s1, mode_s2, inc_s1, inc_s2;
  logic        mode_smp, inc_smp, armed;
  logic [1:0]  state, state_n;
  logic        phase, phase_n;
  logic [31:0] to_cnt, to_cnt_n;
  logic [7:0]  ss_n, mm_n, hh_n;
  logic [3:0]  blank_n;
  logic        colon_n;
  logic        e1, e5, mode_press, inc_press, inc_do, run_tick, timeout;
  logic        state_chg, ss_carry, mm_carry, hh_inc, mm_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hh_wrap(input logic [7:0] v);
`ifdef TIME_12H_EN
    return (v == 8'h12) ? 8'h01 : bcd_inc(v);
`else
    return (v == 8'h23) ? 8'h00 : bcd_inc(v);
`endif
  endfunction

  assign e1 = t1_r & ~t1_p;
  assign e5 = t5_r & ~t5_p;
  // armed blocks a mode button held through reset until it is seen released once
  assign mode_press = e5 & mode_s2 & ~mode_smp & armed;
  assign inc_press  = e5 & inc_s2 & ~inc_smp;
  assign inc_do     = e5 & inc_s2 & ~mode_press & (state != RUN);
  assign run_tick   = e1 & (state == RUN) & ~mode_press;
  assign timeout    = (SET_TIMEOUT_S != 0) && (state != RUN) && e1 && !mode_press
                      && !inc_press && ((to_cnt + 32'd1) == SET_TIMEOUT_S);
  assign ss_carry   = run_tick & (ss_bcd == 8'h59);
  assign mm_carry   = ss_carry & (mm_bcd == 8'h59);
  assign hh_inc     = mm_carry | (inc_do & (state == SET_HH));
  assign mm_inc     = ss_carry | (inc_do & (state == SET_MM));

  always_comb begin
    state_n = state;
    if (mode_press) begin
      case (state)
        RUN:     state_n = SET_HH;
        SET_HH:  state_n = SET_MM;
        default: state_n = RUN;
      endcase
    end else if (timeout) begin
      state_n = RUN;
    end
    state_chg = (state_n != state);

    phase_n = state_chg ? 1'b0 : (e5 ? ~phase : phase);

    blank_n = 4'b0000;
    if (state_n == SET_HH && !inc_do) blank_n = {phase_n, phase_n, 2'b00};
    if (state_n == SET_MM && !inc_do) blank_n = {2'b00, phase_n, phase_n};

    colon_n = colon;
    if (state_n != RUN) colon_n = 1'b1;
    else if (run_tick)  colon_n = ~colon;

    ss_n = ss_bcd;
    if (state != RUN || state_n != RUN) ss_n = 8'h00;
    else if (run_tick)                  ss_n = ss_carry ? 8'h00 : bcd_inc(ss_bcd);

    mm_n = mm_bcd;
    if (mm_inc) mm_n = (mm_bcd == 8'h59) ? 8'h00 : bcd_inc(mm_bcd);

    hh_n = hh_bcd;
    if (hh_inc) hh_n = hh_wrap(hh_bcd);

    to_cnt_n = to_cnt;
    if (state == RUN || state_chg || inc_press) to_cnt_n = '0;
    else if (e1)                                to_cnt_n = to_cnt + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      t1_r     <= 1'b0;
      t1_p     <= 1'b0;
      t5_r     <= 1'b0;
      t5_p     <= 1'b0;
      mode_s1  <= 1'b0;
      mode_s2  <= 1'b0;
      inc_s1   <= 1'b0;
      inc_s2   <= 1'b0;
      mode_smp <= 1'b0;
      inc_smp  <= 1'b0;
      armed    <= 1'b0;
      state    <= RUN;
      phase    <= 1'b0;
      to_cnt   <= '0;
      blank    <= '0;
      colon    <= 1'b1;
      ss_bcd   <= '0;
      mm_bcd   <= '0;
      hh_bcd   <= HH_RST;
    end else begin
      t1_r    <= clk_out_1Hz;
      t1_p    <= t1_r;
      t5_r    <= clk_out_5Hz;
      t5_p    <= t5_r;
      mode_s1 <= btn_mode;
      mode_s2 <= mode_s1;
      inc_s1  <= btn_inc;
      inc_s2  <= inc_s1;
      if (e5) begin
        mode_smp <= mode_s2;
        inc_smp  <= inc_s2;
        if (!mode_s2) armed <= 1'b1;
      end
      state  <= state_n;
      phase  <= phase_n;
      to_cnt <= to_cnt_n;
      // blank only moves on blink/state events so a forced-visible digit stays lit until the next 5 Hz edge
      if (e5 || state_chg) blank <= blank_n;
      colon  <= colon_n;
      ss_bcd <= ss_n;
      mm_bcd <= mm_n;
      hh_bcd <= hh_n;
    end
  end

`ifdef TIME_12H_EN
  always_ff @(posedge clk_in) begin
    if (reset)                           pm <= 1'b0;
    else if (hh_inc && hh_bcd == 8'h11)  pm <= ~pm;
  end
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper; a second instance uses a 3 s set-mode timeout.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset, t1, t5, bm, bi;
  logic [7:0] hh, mm, ss, hh_t, mm_t, ss_t;
  logic [3:0] blank, blank_t;
  logic       colon, pm, colon_t, pm_t;
  int         tests = 0;
  int         fails = 0;

`ifdef TIME_12H_EN
  localparam logic [7:0] HH_RST  = 8'h12;
  localparam logic [7:0] PRE_HH  = 8'h11;
  localparam logic       PRE_PM  = 1'b1;
  localparam logic [7:0] ROLL_HH = 8'h12;
`else
  localparam logic [7:0] HH_RST  = 8'h00;
  localparam logic [7:0] PRE_HH  = 8'h23;
  localparam logic       PRE_PM  = 1'b0;
  localparam logic [7:0] ROLL_HH = 8'h00;
`endif

  always #5 clk = ~clk;

  time_keeper dut (
    .clk_in(clk), .reset(reset), .clk_out_1Hz(t1), .clk_out_5Hz(t5),
    .btn_mode(bm), .btn_inc(bi), .hh_bcd(hh), .mm_bcd(mm), .ss_bcd(ss),
    .blank(blank), .colon(colon), .pm(pm)
  );

  time_keeper #(.SET_TIMEOUT_S(3)) dut_to (
    .clk_in(clk), .reset(reset), .clk_out_1Hz(t1), .clk_out_5Hz(t5),
    .btn_mode(bm), .btn_inc(bi), .hh_bcd(hh_t), .mm_bcd(mm_t), .ss_bcd(ss_t),
    .blank(blank_t), .colon(colon_t), .pm(pm_t)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1();
    @(negedge clk) t1 = 1'b1;
    @(negedge clk) t1 = 1'b0;
    cyc(3);
  endtask

  task automatic tick5();
    @(negedge clk) t5 = 1'b1;
    @(negedge clk) t5 = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bm = 1'b0; bi = 1'b0; t1 = 1'b0; t5 = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    tick5();
  endtask

  task automatic mode_press();
    bm = 1'b1; cyc(3); tick5();
    bm = 1'b0; cyc(3); tick5();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (hh !== HH_RST) begin fails++; $display("FAIL reset_hh: got %h want %h", hh, HH_RST); end
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL reset_mm: got %h want 00", mm); end
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL reset_ss: got %h want 00", ss); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL reset_blank: got %b want 0000", blank); end
    tests++; if (colon !== 1'b1) begin fails++; $display("FAIL reset_colon: got %b want 1", colon); end
    tests++; if (pm !== 1'b0) begin fails++; $display("FAIL reset_pm: got %b want 0", pm); end
    tests++; if (ss_t !== 8'h00) begin fails++; $display("FAIL reset_ss_t: got %h want 00", ss_t); end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk) t1 = 1'b1;
    @(negedge clk);
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL lat_early: got %h want 00", ss); end
    @(negedge clk);
    tests++; if (ss !== 8'h01) begin fails++; $display("FAIL lat_two_edges: got %h want 01", ss); end
    cyc(5);
    tests++; if (ss !== 8'h01) begin fails++; $display("FAIL lat_level_hold: got %h want 01", ss); end
    t1 = 1'b0; cyc(3);
  endtask

  task automatic test_run_count();
    logic [7:0] e;
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      tick1();
      e = 8'(((k % 60) / 10) * 16 + (k % 10));
      tests++; if (ss !== e) begin fails++; $display("FAIL run_ss k=%0d: got %h want %h", k, ss, e); end
      tests++; if (colon !== (k % 2 == 0)) begin fails++; $display("FAIL run_colon k=%0d: got %b want %b", k, colon, (k % 2 == 0)); end
    end
    tests++; if (mm !== 8'h01) begin fails++; $display("FAIL run_mm: got %h want 01", mm); end
    tests++; if (hh !== HH_RST) begin fails++; $display("FAIL run_hh: got %h want %h", hh, HH_RST); end
  endtask

  task automatic test_set_blink();
    logic [3:0] e;
    do_reset();
    repeat (3) tick1();
    tests++; if (ss !== 8'h03) begin fails++; $display("FAIL blink_pre_ss: got %h want 03", ss); end
    mode_press();
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL blink_ss_clear: got %h want 00", ss); end
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL blink_enter: got %b want 1100", blank); end
    tests++; if (colon !== 1'b1) begin fails++; $display("FAIL blink_colon: got %b want 1", colon); end
    for (int i = 0; i < 4; i++) begin
      tick5();
      e = (i % 2 == 0) ? 4'b0000 : 4'b1100;
      tests++; if (blank !== e) begin fails++; $display("FAIL blink_phase i=%0d: got %b want %b", i, blank, e); end
    end
    for (int i = 0; i < 5; i++) begin
      tick1();
      tests++; if (ss !== 8'h00) begin fails++; $display("FAIL blink_ss_frozen i=%0d: got %h want 00", i, ss); end
    end
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL blink_hold: got %b want 1100", blank); end
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp_mm [3];
    exp_mm[0] = 8'h59; exp_mm[1] = 8'h00; exp_mm[2] = 8'h01;
    do_reset();
    mode_press();
    mode_press();
    tests++; if (blank !== 4'b0011) begin fails++; $display("FAIL inc_enter_mm: got %b want 0011", blank); end
    bi = 1'b1; cyc(3);
    repeat (58) tick5();
    tests++; if (mm !== 8'h58) begin fails++; $display("FAIL inc_mm58: got %h want 58", mm); end
    for (int i = 0; i < 3; i++) begin
      tick5();
      tests++; if (mm !== exp_mm[i]) begin fails++; $display("FAIL inc_mm i=%0d: got %h want %h", i, mm, exp_mm[i]); end
      tests++; if (hh !== HH_RST) begin fails++; $display("FAIL inc_hh i=%0d: got %h want %h", i, hh, HH_RST); end
      tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL inc_visible i=%0d: got %b want 0000", i, blank); end
    end
    bi = 1'b0; cyc(3); tick5();
    tests++; if (mm !== 8'h01) begin fails++; $display("FAIL inc_release_mm: got %h want 01", mm); end
    tests++; if (blank !== 4'b0011) begin fails++; $display("FAIL inc_release_blank: got %b want 0011", blank); end
  endtask

  task automatic test_rollover();
    do_reset();
    mode_press();
    bi = 1'b1; cyc(3); repeat (23) tick5(); bi = 1'b0; cyc(3);
    tests++; if (hh !== PRE_HH) begin fails++; $display("FAIL roll_pre_hh: got %h want %h", hh, PRE_HH); end
    tests++; if (pm !== PRE_PM) begin fails++; $display("FAIL roll_pre_pm: got %b want %b", pm, PRE_PM); end
    mode_press();
    bi = 1'b1; cyc(3); repeat (59) tick5(); bi = 1'b0; cyc(3);
    tests++; if (mm !== 8'h59) begin fails++; $display("FAIL roll_pre_mm: got %h want 59", mm); end
    mode_press();
    repeat (59) tick1();
    tests++; if (ss !== 8'h59) begin fails++; $display("FAIL roll_pre_ss: got %h want 59", ss); end
    tick1();
    tests++; if (hh !== ROLL_HH) begin fails++; $display("FAIL roll_hh: got %h want %h", hh, ROLL_HH); end
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL roll_mm: got %h want 00", mm); end
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL roll_ss: got %h want 00", ss); end
    tests++; if (pm !== 1'b0) begin fails++; $display("FAIL roll_pm: got %b want 0", pm); end
  endtask

  task automatic test_timeout();
    do_reset();
    mode_press();
    tests++; if (blank_t !== 4'b1100) begin fails++; $display("FAIL to_enter: got %b want 1100", blank_t); end
    tick1(); tick1();
    tests++; if (blank_t !== 4'b1100) begin fails++; $display("FAIL to_still_set: got %b want 1100", blank_t); end
    tick1();
    tests++; if (blank_t !== 4'b0000) begin fails++; $display("FAIL to_exit_blank: got %b want 0000", blank_t); end
    tests++; if (colon_t !== 1'b1) begin fails++; $display("FAIL to_exit_colon: got %b want 1", colon_t); end
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL to_default_stays: got %b want 1100", blank); end
    tick1();
    tests++; if (ss_t !== 8'h01) begin fails++; $display("FAIL to_run_ss: got %h want 01", ss_t); end
    tests++; if (colon_t !== 1'b0) begin fails++; $display("FAIL to_run_colon: got %b want 0", colon_t); end
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL to_default_ss: got %h want 00", ss); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode_press();
    mode_press();
    bi = 1'b1; cyc(3);
    repeat (3) tick5();
    tests++; if (mm !== 8'h03) begin fails++; $display("FAIL rmid_pre_mm: got %h want 03", mm); end
    @(negedge clk) t5 = 1'b1;
    @(negedge clk) begin t5 = 1'b0; reset = 1'b1; end
    @(negedge clk) reset = 1'b0;
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL rmid_mm: got %h want 00", mm); end
    tests++; if (hh !== HH_RST) begin fails++; $display("FAIL rmid_hh: got %h want %h", hh, HH_RST); end
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL rmid_ss: got %h want 00", ss); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL rmid_blank: got %b want 0000", blank); end
    tests++; if (colon !== 1'b1) begin fails++; $display("FAIL rmid_colon: got %b want 1", colon); end
    tests++; if (pm !== 1'b0) begin fails++; $display("FAIL rmid_pm: got %b want 0", pm); end
    cyc(2); tick5();
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL rmid_inc_ignored: got %h want 00", mm); end
    tick1();
    tests++; if (ss !== 8'h01) begin fails++; $display("FAIL rmid_run_ss: got %h want 01", ss); end
    bi = 1'b0; cyc(3);
  endtask

  task automatic test_mode_tick_collision();
    do_reset();
    repeat (59) tick1();
    tests++; if (ss !== 8'h59) begin fails++; $display("FAIL coll_pre_ss: got %h want 59", ss); end
    bm = 1'b1; cyc(3);
    @(negedge clk) begin t1 = 1'b1; t5 = 1'b1; end
    @(negedge clk) begin t1 = 1'b0; t5 = 1'b0; end
    cyc(3);
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL coll_ss: got %h want 00", ss); end
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL coll_no_carry: got %h want 00", mm); end
    tests++; if (colon !== 1'b1) begin fails++; $display("FAIL coll_colon: got %b want 1", colon); end
    bm = 1'b0; cyc(3); tick5();
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL coll_set_hh: got %b want 1100", blank); end
  endtask

  task automatic test_mode_inc_same_edge();
    bm = 1'b1; bi = 1'b1; cyc(3); tick5();
    tests++; if (hh !== HH_RST) begin fails++; $display("FAIL mi_hh: got %h want %h", hh, HH_RST); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL mi_phase_clear: got %b want 0000", blank); end
    bm = 1'b0; bi = 1'b0; cyc(3); tick5();
    tests++; if (blank !== 4'b0011) begin fails++; $display("FAIL mi_set_mm: got %b want 0011", blank); end
    tests++; if (mm !== 8'h00) begin fails++; $display("FAIL mi_mm: got %h want 00", mm); end
  endtask

  task automatic test_reset_held_mode();
    @(negedge clk) begin bm = 1'b1; bi = 1'b0; reset = 1'b1; end
    cyc(2);
    reset = 1'b0; cyc(3);
    tick5(); tick5();
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL held_blank: got %b want 0000", blank); end
    tick1();
    tests++; if (ss !== 8'h01) begin fails++; $display("FAIL held_still_run: got %h want 01", ss); end
    bm = 1'b0; cyc(3); tick5();
    mode_press();
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL held_repress: got %b want 1100", blank); end
    tests++; if (ss !== 8'h00) begin fails++; $display("FAIL held_repress_ss: got %h want 00", ss); end
  endtask

  initial begin
    reset = 1'b1; t1 = 1'b0; t5 = 1'b0; bm = 1'b0; bi = 1'b0;
    test_reset();
    test_latency();
    test_run_count();
    test_set_blink();
    test_inc_wrap();
    test_rollover();
    test_timeout();
    test_reset_mid();
    test_mode_tick_collision();
    test_mode_inc_same_edge();
    test_reset_held_mode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
